divisor_param: RTL
==================

DIVISOR_PARAM -- requirements
Module: divisor_param

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result bit width (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: inicio  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: dividendo  input  WIDTH  dividend, captured with inicio.
REQ-006 SHALL have port: divisor  input  WIDTH  divisor, captured with inicio.
REQ-007 SHALL have port: cociente  output  WIDTH  registered quotient.
REQ-008 SHALL have port: residuo  output  WIDTH  registered remainder.
REQ-009 SHALL have port: listo  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port: ocupado  output  1  high in every state except IDLE.
REQ-011 SHALL have port: div_cero  output  1  set with listo when captured divisor == 0; held until next accepted inicio.

Function
REQ-012 SHALL implement restoring division with an FSM of states IDLE, BAJAR, COMPARAR, ADD_UNO, ADD_CERO, FIN (plus SIGNO, see REQ-025).
REQ-013 IDLE: inicio=1 at an edge SHALL capture operands, clear partial remainder (WIDTH+1 bits) and partial quotient, load bit counter = WIDTH; go to BAJAR, or to FIN if divisor == 0.
REQ-014 BAJAR: counter == 0 SHALL go to FIN; else shift dividend MSB into remainder LSB, shift dividend left, decrement counter, go to COMPARAR.
REQ-015 COMPARAR: remainder >= divisor (unsigned, WIDTH+1-bit compare) SHALL go to ADD_UNO, else ADD_CERO.
REQ-016 ADD_UNO: remainder -= divisor, shift 1 into quotient LSB, go to BAJAR; ADD_CERO: shift 0 into quotient LSB, go to BAJAR.
REQ-017 FIN: cociente/residuo SHALL load final values on entry; listo=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-018 Latency SHALL be exactly 3*WIDTH+1 edges from the edge sampling inicio to the edge after which listo is high (25 for WIDTH=8).
REQ-019 Divide by zero SHALL give listo 1 edge after inicio, cociente = all ones, residuo = dividendo, div_cero = 1.
REQ-020 inicio while ocupado=1, including during FIN, SHALL be ignored with no effect on the running operation.
REQ-021 cociente/residuo SHALL hold their last values between operations; operand input changes after capture SHALL have no effect.

Reset
REQ-022 rst=0 SHALL immediately, regardless of clk, force IDLE and clear cociente, residuo, listo, ocupado, div_cero and all internal registers to 0.
REQ-023 Reset asserted mid-operation SHALL abort it; no listo pulse SHALL be produced for the aborted operation.
REQ-024 After rst deasserts, the first edge with inicio=1 SHALL start a new operation normally.

Configuration
REQ-025 Macro DIVISOR_SIGNED_EN defined: operands and results two's complement; magnitudes divided unsigned; extra state SIGNO between final BAJAR and FIN negates quotient if operand signs differ and gives remainder the dividend's sign; latency 3*WIDTH+2.
REQ-026 DIVISOR_SIGNED_EN defined: most-negative / -1 SHALL return cociente = most-negative value (wrap), residuo = 0, div_cero = 0; divide by zero per REQ-019.
REQ-027 DIVISOR_SIGNED_EN undefined: SIGNO SHALL not exist; all arithmetic unsigned, latency per REQ-018.

Verification
REQ-028 WIDTH=8 unsigned: dividendo=100, divisor=7, inicio one cycle -> listo exactly 25 edges later, cociente=14, residuo=2, div_cero=0.
REQ-029 WIDTH=8: divisor=0, dividendo=55 -> listo 1 edge later, cociente=255, residuo=55, div_cero=1; next valid op clears div_cero.
REQ-030 WIDTH=8: 200/3 started, inicio pulsed with 9/3 at cycle 10 and again during FIN -> only one listo, cociente=66, residuo=2.
REQ-031 WIDTH=8: rst=0 asynchronously at cycle 12 of an operation -> all outputs 0 before next edge, no listo; 
 fresh 255/255 after release -> cociente=1, residuo=0.
REQ-032 DIVISOR_SIGNED_EN, WIDTH=8: -100/7 -> cociente=-14, residuo=-2 after 26 edges; -128/-1 -> cociente=-128, residuo=0.
REQ-033 WIDTH=16 unsigned: 65535/1 -> cociente=65535, residuo=0, listo after 49 edges; 5/9 -> cociente=0, residuo=5.

Source files
------------

// File: rtl/divisor_param.sv
// divisor_param: multi-cycle restoring divider, unsigned unless DIVISOR_SIGNED_EN is defined
// (then operands/results are two's complement and an extra SIGNO state fixes the result signs).
//
// state    | meaning
// IDLE     | waiting for inicio, results held
// BAJAR    | bring down next dividend bit, or finish when counter reaches 0
// COMPARAR | compare partial remainder against divisor
// ADD_UNO  | subtract divisor, quotient bit 1
// ADD_CERO | quotient bit 0
// SIGNO    | apply result signs (signed build only)
// FIN      | results valid, listo pulse
module divisor_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             listo,
  output logic             ocupado,
  output logic             div_cero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    BAJAR,
    COMPARAR,
    ADD_UNO,
    ADD_CERO,
`ifdef DIVISOR_SIGNED_EN
    SIGNO,
`endif
    FIN
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
`ifdef DIVISOR_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (inicio) state_nxt = (divisor == '0) ? FIN : BAJAR;
`ifdef DIVISOR_SIGNED_EN
      BAJAR:    if (cnt == '0) state_nxt = SIGNO;
                else           state_nxt = COMPARAR;
      SIGNO:    state_nxt = FIN;
`else
      BAJAR:    if (cnt == '0) state_nxt = FIN;
                else           state_nxt = COMPARAR;
`endif
      COMPARAR: state_nxt = (rem >= {1'b0, dvs}) ? ADD_UNO : ADD_CERO;
      ADD_UNO:  state_nxt = BAJAR;
      ADD_CERO: state_nxt = BAJAR;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign listo   = (state == FIN);
  assign ocupado = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      cociente <= '0;
      residuo  <= '0;
      div_cero <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (inicio) begin
          rem      <= '0;
          quo      <= '0;
          cnt      <= CW'(WIDTH);
          div_cero <= (divisor == '0);
`ifdef DIVISOR_SIGNED_EN
          // Divide magnitudes; the most-negative value maps onto its own unsigned pattern.
          dvd      <= dividendo[WIDTH-1] ? -dividendo : dividendo;
          dvs      <= divisor[WIDTH-1] ? -divisor : divisor;
          neg_q    <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r    <= dividendo[WIDTH-1];
`else
          dvd      <= dividendo;
          dvs      <= divisor;
`endif
          if (divisor == '0) begin
            cociente <= '1;
            residuo  <= dividendo;
          end
        end
        BAJAR: if (cnt == '0) begin
`ifndef DIVISOR_SIGNED_EN
          cociente <= quo;
          residuo  <= rem[WIDTH-1:0];
`endif
        end else begin
          rem <= {rem[WIDTH-1:0], dvd[WIDTH-1]};
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        ADD_UNO: begin
          rem <= rem - {1'b0, dvs};
          quo <= {quo[WIDTH-2:0], 1'b1};
        end
        ADD_CERO: quo <= {quo[WIDTH-2:0], 1'b0};
`ifdef DIVISOR_SIGNED_EN
        SIGNO: begin
          cociente <= neg_q ? -quo : quo;
          residuo  <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
